instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the processor's instruction decoder: takes decoded instruction fields over a valid/ready stream, packs them into 32-bit ISA words and writes them sequentially into instruction memory.
- Used by the boot/debug path to load programs into imem at run time.
- Validates opcodes and field ranges, and counts words per load session.

Parameters:
ADDR_W, 12, imem word-address width; addresses wrap modulo 2^ADDR_W

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a load session; ignored unless IDLE
base_addr  in  ADDR_W  first imem address, sampled on start
word_count  in  ADDR_W+1  number of words to write, sampled on start
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle
in_opcode  in  5  opcode
in_rd / in_rs / in_rt / in_shamt / in_aluop  in  5 each  register and ALU fields
in_immed  in  32  signed immediate
in_target  in  32  unsigned jump target
imem_wren  out  1  imem write enable
imem_addr  out  ADDR_W  imem address
imem_data  out  32  imem write data
imem_q  in  32  imem read data, 1-cycle synchronous latency; used only with the macro
busy  out  1  session in progress
done  out  1  one-cycle pulse at session end
words_written  out  ADDR_W+1  words committed in the current or last session
err_illegal  out  1  sticky: a bundle with an unsupported opcode was rejected
err_range  out  1  sticky: a bundle's immediate or target was out of range
err_verify  out  1  sticky: readback mismatch (macro only; tied 0 otherwise)

Behaviour:
- Reset: async, active-low. FSM to IDLE. All outputs 0, including error flags and words_written. No write may occur during or after reset assertion.
- Clock and reset: one clock; reset is asynchronous and active-low (clock, reset_n).
- Word layout: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], immed[16:0], target[26:0].
- R class, op 0: {op, rd, rs, rt, shamt, aluop, 2'b00}.
- I class, op 2, 5, 6, 7, 8: {op, rd, rs, immed[16:0]}.
  - Range rule: in_immed must lie in -65536..65535, i.e. bits [31:16] all equal; otherwise err_range.
- JI class, op 1, 3, 21, 22: {op, target[26:0]}.
  - Range rule: in_target[31:27] must be 0; otherwise err_range.
- JII class, op 4: {op, rd, 22'b0}.
- Any other opcode sets err_illegal.
- States: IDLE, ACCEPT, WRITE, DONE; VERIFY_RD and VERIFY_CK only with the macro.
- IDLE:
  - On start: latch base and count, clear errors and words_written, index=0, busy=1.
  - count==0: go to DONE. Otherwise go to ACCEPT.
- ACCEPT:
  - in_ready=1; a handshake is in_valid & in_ready.
  - Valid bundle: register the encoded word, go to WRITE.
  - Rejected bundle: it is consumed, its error flag is set, nothing is written, index is unchanged, FSM stays in ACCEPT.
  - If both illegal and out of range, only err_illegal is set.
- WRITE:
  - in_ready=0. imem_wren=1 for exactly one cycle, imem_addr=(base+index) mod 2^ADDR_W, imem_data=registered word.
  - Then increment index and words_written.
  - Without the macro: go to DONE if index==count, else to ACCEPT.
- DONE: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Latency and throughput: handshake in cycle N gives the write in cycle N+1. Peak rate is 1 word per 2 cycles.
- Outside WRITE, imem_wren=0; imem_addr and imem_data hold their last values.
- start while busy is ignored. in_valid in IDLE or DONE is not accepted.
- Reset mid-session aborts the session immediately; already-written words remain in imem.

Optional Feature:
- Macro READBACK_VERIFY_EN.
- Defined:
  - WRITE goes to VERIFY_RD, which holds imem_addr with wren=0.
  - VERIFY_RD goes to VERIFY_CK, which compares imem_q to the registered word. A mismatch sets err_verify; the session continues.
  - Then go to DONE or ACCEPT as above. Throughput becomes 1 word per 4 cycles.
- Undefined: imem_q is ignored, err_verify is constant 0, and no verify states exist.

Test Plan:
- start base=0x010 count=3. Send add rd3 rs1 rt2 shamt0 aluop0, then addi rd1 rs0 imm=-1, then j target=100 -> writes 0x00C22000@0x010, 0x2841FFFF@0x011, 0x08000064@0x012; done pulses once; words_written=3.
- lw with imm=65536 -> err_range=1, no imem_wren, words_written unchanged. A following valid lw is written at the same address.
- opcode 9 -> err_illegal=1, no write. The next start clears both error flags.
- ADDR_W=12, base=0xFFF count=2 -> writes at 0xFFF then 0x000.
- start with count=0 -> done pulses within 2 cycles, no writes. start pulsed while busy -> no effect on base or count.
- reset_n low mid-session -> imem_wren, busy and done go 0 immediately. With READBACK_VERIFY_EN, forcing imem_q to differ -> err_verify=1.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: decoded-field stream into the loader and the imem write/readback bus out of it
interface instr_encoder_loader_if #(parameter int ADDR_W = 12);
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_opcode;
   logic [4:0]        in_rd;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_shamt;
   logic [4:0]        in_aluop;
   logic [31:0]       in_immed;
   logic [31:0]       in_target;
   logic              imem_wren;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_data;
   logic [31:0]       imem_q;
   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_immed, in_target, imem_q,
      output in_ready, imem_wren, imem_addr, imem_data
   );
   modport master (
      output in_valid, in_opcode, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_immed, in_target, imem_q,
      input  in_ready, imem_wren, imem_addr, imem_data
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded fields into 32-bit ISA words and writes them to imem; READBACK_VERIFY_EN adds a readback check per word
module instr_encoder_loader #(
   parameter int ADDR_W = 12
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       word_count,
   instr_encoder_loader_if.slave bus,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W:0]       words_written,
   output logic                  err_illegal,
   output logic                  err_range,
   output logic                  err_verify
);
`ifdef READBACK_VERIFY_EN
   typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, VERIFY_RD, VERIFY_CK} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
`endif
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d, idx_q, idx_d;
   logic [31:0]       word_q, word_d, enc;
   logic              ill_q, ill_d, rng_q, rng_d, ver_q, ver_d;
   logic              is_r, is_i, is_ji, is_jii, illegal, bad_range;
   // classify the offered opcode, apply its range rule and pack the ISA word
   always_comb begin
      is_r      = bus.in_opcode == 5'd0;
      is_i      = bus.in_opcode inside {5'd2, 5'd5, 5'd6, 5'd7, 5'd8};
      is_ji     = bus.in_opcode inside {5'd1, 5'd3, 5'd21, 5'd22};
      is_jii    = bus.in_opcode == 5'd4;
      illegal   = !(is_r || is_i || is_ji || is_jii);
      bad_range = (is_i && !(&bus.in_immed[31:16] || ~|bus.in_immed[31:16])) || (is_ji && |bus.in_target[31:27]);
      enc       = is_r  ? {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_shamt, bus.in_aluop, 2'b00} :
                  is_i  ? {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_immed[16:0]} :
                  is_ji ? {bus.in_opcode, bus.in_target[26:0]} :
                          {bus.in_opcode, bus.in_rd, 22'b0};
   end
   // session FSM: accept bundles, write one word per accepted bundle, count and flag errors
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      count_d = count_q;
      idx_d   = idx_q;
      word_d  = word_q;
      addr_d  = addr_q;
      ill_d   = ill_q;
      rng_d   = rng_q;
      ver_d   = ver_q;
      case (state_q)
         IDLE: if (start) begin
            base_d  = base_addr;
            count_d = word_count;
            idx_d   = '0;
            ill_d   = 1'b0;
            rng_d   = 1'b0;
            ver_d   = 1'b0;
            state_d = word_count == '0 ? DONE : ACCEPT;
         end
         ACCEPT: if (bus.in_valid) begin
            if (illegal) ill_d = 1'b1;
            else if (bad_range) rng_d = 1'b1;
            else begin
               word_d  = enc;
               addr_d  = base_q + idx_q[ADDR_W-1:0];
               state_d = WRITE;
            end
         end
         WRITE: begin
            idx_d = idx_q + 1'b1;
`ifdef READBACK_VERIFY_EN
            state_d = VERIFY_RD;
`else
            state_d = (idx_q + 1'b1) == count_q ? DONE : ACCEPT;
`endif
         end
`ifdef READBACK_VERIFY_EN
         VERIFY_RD: state_d = VERIFY_CK;
         VERIFY_CK: begin
            if (bus.imem_q != word_q) ver_d = 1'b1;
            state_d = idx_q == count_q ? DONE : ACCEPT;
         end
`endif
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers; reset aborts any session at once
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         ill_q   <= 1'b0;
         rng_q   <= 1'b0;
         ver_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         ill_q   <= ill_d;
         rng_q   <= rng_d;
         ver_q   <= ver_d;
      end
   end
`ifdef READBACK_VERIFY_EN
   assign err_verify = ver_q;
`else
   logic unused_q;
   assign unused_q   = ^{bus.imem_q, ver_q};
   assign err_verify = 1'b0;
`endif
   assign bus.in_ready   = state_q == ACCEPT;
   assign bus.imem_wren  = state_q == WRITE;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_data  = word_q;
   assign busy           = state_q != IDLE;
   assign done           = state_q == DONE;
   assign words_written  = idx_q;
   assign err_illegal    = ill_q;
   assign err_range      = rng_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: randomized scoreboard bench for the encoder/loader against a field-arithmetic model
module tb_instr_encoder_loader;
   typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
   logic        clock = 0, reset_n, start, busy, done, err_illegal, err_range, err_verify, corrupt;
   logic [11:0] base_addr, exp_base;
   logic [12:0] word_count, words_written;
   logic [31:0] mem [0:4095];
   logic [4:0]  legal_ops [11];
   wr_t         exp_q[$];
   wr_t         e;
   int          checks = 0, errors = 0, done_cnt = 0, done0, exp_idx;
   logic        exp_ill, exp_rng, exp_ver;
   instr_encoder_loader_if #(.ADDR_W(12)) bus();
   instr_encoder_loader #(.ADDR_W(12)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr), .word_count(word_count),
      .bus(bus), .busy(busy), .done(done), .words_written(words_written),
      .err_illegal(err_illegal), .err_range(err_range), .err_verify(err_verify)
   );
   always #5 clock = ~clock;
   // imem with one-cycle synchronous read; corrupt flips bit 0 of readback
   always @(posedge clock) begin
      if (bus.imem_wren) mem[bus.imem_addr] <= bus.imem_data;
      bus.imem_q <= mem[bus.imem_addr] ^ {31'b0, corrupt};
   end
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask
   // monitor: every imem write must match the next scoreboard entry
   always @(negedge clock) begin
      if (done) done_cnt++;
      if (bus.imem_wren) begin
         if (exp_q.size() == 0) chk("unexpected_write", {bus.imem_addr, bus.imem_data}, 0);
         else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.imem_addr, e.a);
            chk("wr_data", bus.imem_data, e.d);
         end
      end
   end
   // reference: 0 ok, 1 illegal, 2 out of range; word built from field weights
   function automatic int model(input logic [4:0] op, rd, rs, rt, sh, al, input logic [31:0] imm, tgt, output logic [31:0] w);
      longint si = longint'($signed(imm));
      w = 0;
      case (op)
         0: w = op * 134217728 + rd * 4194304 + rs * 131072 + rt * 4096 + sh * 128 + al * 4;
         2, 5, 6, 7, 8: begin
            if (si < -65536 || si > 65535) return 2;
            w = op * 134217728 + rd * 4194304 + rs * 131072 + imm % 32'd131072;
         end
         1, 3, 21, 22: begin
            if (tgt >= 32'd134217728) return 2;
            w = op * 134217728 + tgt;
         end
         4: w = op * 134217728 + rd * 4194304;
         default: return 1;
      endcase
      return 0;
   endfunction
   task automatic send(input logic [4:0] op, rd, rs, rt, sh, al, input logic [31:0] imm, tgt, lit, input bit use_lit);
      logic [31:0] w;
      int st, n = 0;
      st = model(op, rd, rs, rt, sh, al, imm, tgt, w);
      {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_shamt, bus.in_aluop} = {op, rd, rs, rt, sh, al};
      bus.in_immed = imm;
      bus.in_target = tgt;
      bus.in_valid = 1;
      while (!bus.in_ready && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (!bus.in_ready) begin
         chk("ready_timeout", 0, 1);
         bus.in_valid = 0;
         return;
      end
      if (st == 0) begin
         exp_q.push_back('{a: exp_base + 12'(exp_idx), d: use_lit ? lit : w});
         exp_idx++;
      end else if (st == 1) exp_ill = 1;
      else exp_rng = 1;
      @(negedge clock);
      bus.in_valid = 0;
      chk("wren_latency", bus.imem_wren, st == 0);
   endtask
   task automatic rand_bundle();
      logic [4:0]  op;
      logic [31:0] imm, tgt;
      op  = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 10)] : 5'($urandom);
      imm = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 131071)) - 32'd65536 : $urandom;
      tgt = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 134217727)) : $urandom;
      send(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, tgt, 0, 0);
   endtask
   task automatic begin_session(input logic [11:0] b, input logic [12:0] c);
      done0 = done_cnt;
      @(negedge clock);
      start = 1;
      base_addr = b;
      word_count = c;
      @(negedge clock);
      start = 0;
      base_addr = 12'($urandom);
      word_count = 13'($urandom);
      exp_base = b;
      exp_idx = 0;
      exp_ill = 0;
      exp_rng = 0;
      exp_ver = 0;
      chk("busy_after_start", busy, 1);
      chk("errs_cleared", {err_illegal, err_range, err_verify}, 0);
   endtask
   task automatic end_session();
      int n = 0;
      while (busy && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk("session_end", busy, 0);
      chk("done_pulses", done_cnt - done0, 1);
      chk("words_written", words_written, exp_idx);
      chk("err_illegal", err_illegal, exp_ill);
      chk("err_range", err_range, exp_rng);
      chk("err_verify", err_verify, exp_ver);
      chk("sb_empty", exp_q.size(), 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
   initial begin
      legal_ops = '{0, 2, 5, 6, 7, 8, 1, 3, 21, 22, 4};
      reset_n = 0;
      start = 0;
      corrupt = 0;
      base_addr = 0;
      word_count = 0;
      bus.in_valid = 0;
      {bus.in_opcode, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_shamt, bus.in_aluop} = '0;
      bus.in_immed = 0;
      bus.in_target = 0;
      repeat (3) @(negedge clock);
      chk("rst_outputs", {busy, done, bus.imem_wren, bus.in_ready, err_illegal, err_range, err_verify}, 0);
      chk("rst_words", words_written, 0);
      chk("rst_addr_data", {bus.imem_addr, bus.imem_data}, 0);
      reset_n = 1;
      begin_session(12'h010, 3);
      send(0, 3, 1, 2, 0, 0, 0, 0, 32'h00C22000, 1);
      send(5, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 32'h2841FFFF, 1);
      send(1, 0, 0, 0, 0, 0, 0, 100, 32'h08000064, 1);
      end_session();
      begin_session(12'h200, 1);
      send(2, 4, 5, 0, 0, 0, 32'd65536, 0, 0, 0);
      chk("ww_after_reject", words_written, 0);
      chk("range_flag_now", err_range, 1);
      send(2, 4, 5, 0, 0, 0, 32'd65535, 0, 0, 0);
      end_session();
      begin_session(12'h300, 1);
      send(9, 1, 1, 1, 1, 1, 32'h12345678, 32'hF0000000, 0, 0);
      chk("illegal_no_write", words_written, 0);
      send(4, 7, 0, 0, 0, 0, 0, 0, 32'h21C00000, 1);
      end_session();
      begin_session(12'hFFF, 2);
      send(6, 2, 3, 0, 0, 0, 32'hFFFF0000, 0, 0, 0);
      send(22, 0, 0, 0, 0, 0, 0, 32'h07FFFFFF, 0, 0);
      end_session();
      begin_session(12'h123, 0);
      @(negedge clock);
      chk("zero_done_quick", done_cnt - done0, 1);
      chk("zero_idle", busy, 0);
      end_session();
      begin_session(12'h100, 4);
      send(7, 1, 2, 0, 0, 0, 32'd5, 0, 0, 0);
      bus.in_opcode = 0;
      bus.in_valid = 1;
      for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge clock);
      @(posedge clock);
      #1 reset_n = 0;
      #1 chk("abort_outputs", {bus.imem_wren, busy, done, bus.in_ready}, 0);
      bus.in_valid = 0;
      repeat (2) @(negedge clock);
      reset_n = 1;
      chk("abort_state", {words_written, err_illegal, err_range, err_verify}, 0);
      exp_q.delete();
`ifdef READBACK_VERIFY_EN
      begin_session(12'h400, 2);
      corrupt = 1;
      rand_bundle();
      while (exp_idx < 2) rand_bundle();
      exp_ver = 1;
      end_session();
      corrupt = 0;
`endif
      for (int s = 0; s < 25; s++) begin
         int cnt = $urandom_range(1, 6);
         begin_session(12'($urandom), 13'(cnt));
         start = 1;
         base_addr = 12'($urandom);
         word_count = 13'($urandom);
         @(negedge clock);
         start = 0;
         for (int k = 0; k < 200 && exp_idx < cnt; k++) rand_bundle();
         end_session();
      end
      repeat (2) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
